// File: rtl/avalon_bridge_arbiter.sv
// Purpose: round-robin arbiter sharing one Avalon-MM register target between the HPS bridge and a fabric master.
// Latency: strobe one cycle after the grant; completion one cycle after target accept (abort after TIMEOUT_CYCLES).
// Backpressure: waitrequest held high except the single RESP cycle; one transfer outstanding at a time.
module avalon_bridge_arbiter #(
  parameter int                ADDR_W         = 8,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] hps_address,
  input  logic              hps_read,
  input  logic              hps_write,
  input  logic [DATA_W-1:0] hps_writedata,
  output logic [DATA_W-1:0] hps_readdata,
  output logic              hps_waitrequest,
  input  logic [ADDR_W-1:0] fab_address,
  input  logic              fab_read,
  input  logic              fab_write,
  input  logic [DATA_W-1:0] fab_writedata,
  output logic [DATA_W-1:0] fab_readdata,
  output logic              fab_waitrequest,
  output logic [ADDR_W-1:0] tgt_address,
  output logic              tgt_read,
  output logic              tgt_write,
  output logic [DATA_W-1:0] tgt_writedata,
  input  logic [DATA_W-1:0] tgt_readdata,
  input  logic              tgt_waitrequest,
  input  logic              err_clr,
  output logic              err_timeout,
  output logic              grant_hps,
  output logic              busy
);

  // Timer only has to count 0 .. TIMEOUT_CYCLES-1.
  localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Holding register for the granted transfer; doubles as the target-side drivers.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdat;
    logic              rnw;
  } xfer_t;

  state_e            state_q, state_d;
  xfer_t             xfer_q, xfer_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              tgt_read_q, tgt_read_d;
  logic              tgt_write_q, tgt_write_d;
  logic              hps_wait_q, hps_wait_d;
  logic              fab_wait_q, fab_wait_d;
  logic [DATA_W-1:0] hps_rdat_q, hps_rdat_d;
  logic [DATA_W-1:0] fab_rdat_q, fab_rdat_d;
  logic              err_q, err_d;
  logic              grant_hps_q, grant_hps_d;
  logic              last_hps_q, last_hps_d;
  logic              busy_q, busy_d;

  logic              hps_req, fab_req, pick_hps;
  logic              acc_done, acc_tout, err_set;
  logic [DATA_W-1:0] cap_dat;

  // Request decode and round-robin pick: on a tie the master not served last wins.
  always_comb begin
    hps_req  = hps_read | hps_write;
    fab_req  = fab_read | fab_write;
    pick_hps = hps_req & (~fab_req | ~last_hps_q);
  end

  // Next-state and next-output computation for the whole arbiter.
  always_comb begin
    state_d     = state_q;
    xfer_d      = xfer_q;
    tmr_d       = tmr_q;
    tgt_read_d  = tgt_read_q;
    tgt_write_d = tgt_write_q;
    hps_wait_d  = 1'b1;
    fab_wait_d  = 1'b1;
    hps_rdat_d  = hps_rdat_q;
    fab_rdat_d  = fab_rdat_q;
    grant_hps_d = grant_hps_q;
    last_hps_d  = last_hps_q;
    err_set     = 1'b0;
    acc_done    = ~tgt_waitrequest;
    acc_tout    = (tmr_q == TMR_LAST);
    cap_dat     = acc_done ? tgt_readdata : TIMEOUT_DATA;

    case (state_q)
      ST_IDLE: begin
        if (hps_req | fab_req) begin
          // read&write together decodes as a write (rnw = !write).
          xfer_d.addr = pick_hps ? hps_address : fab_address;
          xfer_d.wdat = pick_hps ? hps_writedata : fab_writedata;
          xfer_d.rnw  = pick_hps ? ~hps_write : ~fab_write;
          grant_hps_d = pick_hps;
          tmr_d       = '0;
          tgt_read_d  = xfer_d.rnw;
          tgt_write_d = ~xfer_d.rnw;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (acc_done || acc_tout) begin
          tgt_read_d  = 1'b0;
          tgt_write_d = 1'b0;
          err_set     = ~acc_done;
          if (grant_hps_q) begin
            hps_wait_d = 1'b0;
            if (xfer_q.rnw) hps_rdat_d = cap_dat;
          end else begin
            fab_wait_d = 1'b0;
            if (xfer_q.rnw) fab_rdat_d = cap_dat;
          end
          state_d = ST_RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_RESP: begin
        last_hps_d = grant_hps_q;
        state_d    = ST_IDLE;
      end
      default: begin
        tgt_read_d  = 1'b0;
        tgt_write_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // Sticky error: a new timeout wins over a coincident clear.
    err_d  = (err_q & ~err_clr) | err_set;
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops the target strobes immediately.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      xfer_q      <= '0;
      tmr_q       <= '0;
      tgt_read_q  <= 1'b0;
      tgt_write_q <= 1'b0;
      hps_wait_q  <= 1'b1;
      fab_wait_q  <= 1'b1;
      hps_rdat_q  <= '0;
      fab_rdat_q  <= '0;
      err_q       <= 1'b0;
      grant_hps_q <= 1'b0;
      last_hps_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      xfer_q      <= xfer_d;
      tmr_q       <= tmr_d;
      tgt_read_q  <= tgt_read_d;
      tgt_write_q <= tgt_write_d;
      hps_wait_q  <= hps_wait_d;
      fab_wait_q  <= fab_wait_d;
      hps_rdat_q  <= hps_rdat_d;
      fab_rdat_q  <= fab_rdat_d;
      err_q       <= err_d;
      grant_hps_q <= grant_hps_d;
      last_hps_q  <= last_hps_d;
      busy_q      <= busy_d;
    end
  end

  assign tgt_address     = xfer_q.addr;
  assign tgt_writedata   = xfer_q.wdat;
  assign tgt_read        = tgt_read_q;
  assign tgt_write       = tgt_write_q;
  assign hps_waitrequest = hps_wait_q;
  assign fab_waitrequest = fab_wait_q;
  assign hps_readdata    = hps_rdat_q;
  assign fab_readdata    = fab_rdat_q;
  assign err_timeout     = err_q;
  assign grant_hps       = grant_hps_q;
  assign busy            = busy_q;

endmodule
